// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: per-stage enable/flush, EX forwarding selects,
// MDU wait FSM with timeout flag, and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MDU_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       rd_E,
  input  logic             mem_read_E,
  input  logic [4:0]       rd_M,
  input  logic             reg_write_M,
  input  logic [4:0]       rd_W,
  input  logic             reg_write_W,
  input  logic             br_taken_E,
  input  logic             mdu_start_E,
  input  logic             mdu_done,
  output logic             enable_F,
  output logic             enable_D,
  output logic             enable_E,
  output logic             flush_D,
  output logic             flush_E,
  output logic [1:0]       fwd_a_E,
  output logic [1:0]       fwd_b_E,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mdu_timeout
);

  localparam int WCW = $clog2(MDU_TIMEOUT + 1);
  localparam logic [WCW-1:0] TIMEOUT_VAL = WCW'(MDU_TIMEOUT);

  // busy is the externally visible copy of the FSM state (1 == MDU_WAIT).
  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           mdu_stall;
  logic           load_use;
  logic [WCW-1:0] wait_cnt;
  logic [WCW-1:0] wait_cnt_nxt;

  always_comb begin
    state_nxt = state;
    mdu_stall = 1'b0;
    case (state)
      RUN: begin
        if (mdu_start_E) begin
          state_nxt = MDU_WAIT;
          mdu_stall = 1'b1;
        end
      end
      MDU_WAIT: begin
        if (mdu_done) state_nxt = RUN;
        else          mdu_stall = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign load_use = mem_read_E && (rd_E != 5'd0) && ((rd_E == rs1_D) || (rd_E == rs2_D));

  // Priority: MDU stall > taken branch > load-use. All forced benign while in reset.
  always_comb begin
    enable_F = 1'b1;
    enable_D = 1'b1;
    enable_E = 1'b1;
    flush_D  = 1'b0;
    flush_E  = 1'b0;
    if (rst_n) begin
      if (mdu_stall) begin
        enable_F = 1'b0;
        enable_D = 1'b0;
        enable_E = 1'b0;
      end else if (br_taken_E) begin
        flush_D = 1'b1;
        flush_E = 1'b1;
      end else if (load_use) begin
        enable_F = 1'b0;
        enable_D = 1'b0;
        flush_E  = 1'b1;
      end
    end
  end

  // MEM result is younger than WB, so it wins when both match.
  always_comb begin
    fwd_a_E = 2'b00;
    fwd_b_E = 2'b00;
    if (rst_n) begin
      if (reg_write_M && (rd_M != 5'd0) && (rd_M == rs1_E))      fwd_a_E = 2'b10;
      else if (reg_write_W && (rd_W != 5'd0) && (rd_W == rs1_E)) fwd_a_E = 2'b01;
      if (reg_write_M && (rd_M != 5'd0) && (rd_M == rs2_E))      fwd_b_E = 2'b10;
      else if (reg_write_W && (rd_W != 5'd0) && (rd_W == rs2_E)) fwd_b_E = 2'b01;
    end
  end

  assign busy = rst_n && (state == MDU_WAIT);

  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if (state == RUN && mdu_start_E)                        wait_cnt_nxt = '0;
    else if (state == MDU_WAIT && wait_cnt != TIMEOUT_VAL)  wait_cnt_nxt = wait_cnt + WCW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mdu_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      // Flag only; the FSM keeps waiting for mdu_done.
      if (state == MDU_WAIT && wait_cnt_nxt == TIMEOUT_VAL) mdu_timeout <= 1'b1;
      if (!enable_D && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_D && flush_cnt != '1)   flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized run against a
// behavioural model of the hazard rules.
module tb_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int TMO   = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [4:0]       rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic             mem_read_E, reg_write_M, reg_write_W, br_taken_E, mdu_start_E, mdu_done;
  logic             enable_F, enable_D, enable_E, flush_D, flush_E, busy, mdu_timeout;
  logic [1:0]       fwd_a_E, fwd_b_E;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [4:0]       ctl;

  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] exp_q[$];

  hazard_ctrl #(.CNT_W(CNT_W), .MDU_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
    .mem_read_E(mem_read_E), .rd_M(rd_M), .reg_write_M(reg_write_M),
    .rd_W(rd_W), .reg_write_W(reg_write_W), .br_taken_E(br_taken_E),
    .mdu_start_E(mdu_start_E), .mdu_done(mdu_done),
    .enable_F(enable_F), .enable_D(enable_D), .enable_E(enable_E),
    .flush_D(flush_D), .flush_E(flush_E), .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E),
    .busy(busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mdu_timeout(mdu_timeout)
  );

  assign ctl = {enable_F, enable_D, enable_E, flush_D, flush_E};

  // Clock / reset
  always #5 clk = ~clk;

  task automatic clear_inputs();
    rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
    mem_read_E = 0; reg_write_M = 0; reg_write_W = 0; br_taken_E = 0;
    mdu_start_E = 0; mdu_done = 0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference forwarding choice: MEM result beats WB, x0 never forwarded.
  function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input logic wm, input logic [4:0] rm,
                                         input logic ww, input logic [4:0] rw);
    if (wm && rm != 0 && rm == rs) return 2'b10;
    if (ww && rw != 0 && rw == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    mdu_start_E = 1; br_taken_E = 1; mem_read_E = 1; rd_E = 4; rs1_D = 4;
    reg_write_M = 1; rd_M = 6; rs1_E = 6; rs2_E = 6;
    #2;
    n_cmp++; if (ctl !== 5'b11100) begin n_bad++; $display("FAIL reset_ctl: got %b want 11100", ctl); end
    n_cmp++; if ({fwd_a_E, fwd_b_E} !== 4'b0000) begin n_bad++; $display("FAIL reset_fwd: got %b want 0000", {fwd_a_E, fwd_b_E}); end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if ({stall_cnt, flush_cnt, mdu_timeout} !== '0) begin n_bad++; $display("FAIL reset_regs: got %h/%h/%b want 0/0/0", stall_cnt, flush_cnt, mdu_timeout); end
    reset_dut();
  endtask

  task automatic test_load_use();
    reset_dut();
    mem_read_E = 1; rd_E = 5; rs1_D = 5;
    @(negedge clk);
    n_cmp++; if (ctl !== 5'b00101) begin n_bad++; $display("FAIL load_use_ctl: got %b want 00101", ctl); end
    n_cmp++; if (stall_cnt !== 0) begin n_bad++; $display("FAIL load_use_cnt0: got %0d want 0", stall_cnt); end
    tick();
    clear_inputs();
    @(negedge clk);
    n_cmp++; if (stall_cnt !== 1) begin n_bad++; $display("FAIL load_use_cnt1: got %0d want 1", stall_cnt); end
    n_cmp++; if (ctl !== 5'b11100) begin n_bad++; $display("FAIL load_use_release: got %b want 11100", ctl); end
    tick();
    mem_read_E = 1; rd_E = 9; rs2_D = 9; rs1_D = 3;
    @(negedge clk);
    n_cmp++; if (ctl !== 5'b00101) begin n_bad++; $display("FAIL load_use_rs2: got %b want 00101", ctl); end
    tick();
    clear_inputs();
  endtask

  task automatic test_load_use_x0();
    reset_dut();
    mem_read_E = 1; rd_E = 0; rs1_D = 0;
    @(negedge clk);
    n_cmp++; if (ctl !== 5'b11100) begin n_bad++; $display("FAIL load_x0_ctl: got %b want 11100", ctl); end
    tick();
    clear_inputs();
    @(negedge clk);
    n_cmp++; if (stall_cnt !== 0) begin n_bad++; $display("FAIL load_x0_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_branch_priority();
    reset_dut();
    br_taken_E = 1; mem_read_E = 1; rd_E = 5; rs1_D = 5;
    @(negedge clk);
    n_cmp++; if (ctl !== 5'b11111) begin n_bad++; $display("FAIL branch_ctl: got %b want 11111", ctl); end
    tick();
    clear_inputs();
    @(negedge clk);
    n_cmp++; if (flush_cnt !== 1) begin n_bad++; $display("FAIL branch_flush_cnt: got %0d want 1", flush_cnt); end
    n_cmp++; if (stall_cnt !== 0) begin n_bad++; $display("FAIL branch_stall_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_mdu();
    reset_dut();
    mdu_start_E = 1;
    br_taken_E = 1;
    for (int c = 0; c <= 5; c++) begin
      if (c == 4) mdu_done = 1;
      if (c == 5) begin mdu_done = 0; mdu_start_E = 0; br_taken_E = 0; end
      @(negedge clk);
      if (c < 4) begin
        n_cmp++; if (ctl !== 5'b00000) begin n_bad++; $display("FAIL mdu_ctl_c%0d: got %b want 00000", c, ctl); end
      end else if (c == 4) begin
        n_cmp++; if (ctl !== 5'b11111) begin n_bad++; $display("FAIL mdu_ctl_c%0d: got %b want 11111", c, ctl); end
      end else begin
        n_cmp++; if (ctl !== 5'b11100) begin n_bad++; $display("FAIL mdu_ctl_c%0d: got %b want 11100", c, ctl); end
      end
      n_cmp++; if (busy !== (c >= 1 && c <= 4)) begin n_bad++; $display("FAIL mdu_busy_c%0d: got %b want %b", c, busy, (c >= 1 && c <= 4)); end
      tick();
    end
    @(negedge clk);
    n_cmp++; if (stall_cnt !== 4) begin n_bad++; $display("FAIL mdu_stall_cnt: got %0d want 4", stall_cnt); end
    n_cmp++; if (flush_cnt !== 1) begin n_bad++; $display("FAIL mdu_flush_cnt: got %0d want 1", flush_cnt); end
    mdu_done = 1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || ctl !== 5'b11100) begin n_bad++; $display("FAIL mdu_done_in_run: got busy=%b ctl=%b want 0/11100", busy, ctl); end
    tick();
    clear_inputs();
  endtask

  task automatic test_forwarding();
    reset_dut();
    reg_write_M = 1; rd_M = 7; reg_write_W = 1; rd_W = 7; rs1_E = 7; rs2_E = 3;
    @(negedge clk);
    n_cmp++; if (fwd_a_E !== 2'b10) begin n_bad++; $display("FAIL fwd_mem_wins: got %b want 10", fwd_a_E); end
    n_cmp++; if (fwd_b_E !== 2'b00) begin n_bad++; $display("FAIL fwd_b_none: got %b want 00", fwd_b_E); end
    rd_M = 0; rs2_E = 7;
    @(negedge clk);
    n_cmp++; if (fwd_a_E !== 2'b01) begin n_bad++; $display("FAIL fwd_wb: got %b want 01", fwd_a_E); end
    n_cmp++; if (fwd_b_E !== 2'b01) begin n_bad++; $display("FAIL fwd_b_wb: got %b want 01", fwd_b_E); end
    rd_M = 7; reg_write_M = 0; reg_write_W = 0; rs2_E = 0;
    @(negedge clk);
    n_cmp++; if ({fwd_a_E, fwd_b_E} !== 4'b0000) begin n_bad++; $display("FAIL fwd_nowrite: got %b want 0000", {fwd_a_E, fwd_b_E}); end
    reg_write_M = 1; rs1_E = 2; rs2_E = 7;
    @(negedge clk);
    n_cmp++; if ({fwd_a_E, fwd_b_E} !== 4'b0010) begin n_bad++; $display("FAIL fwd_b_mem: got %b want 0010", {fwd_a_E, fwd_b_E}); end
    clear_inputs();
  endtask

  task automatic test_saturation();
    reset_dut();
    mem_read_E = 1; rd_E = 2; rs1_D = 2;
    repeat (CMAX + 5) tick();
    @(negedge clk);
    n_cmp++; if (stall_cnt !== CNT_W'(CMAX)) begin n_bad++; $display("FAIL stall_sat: got %0d want %0d", stall_cnt, CMAX); end
    br_taken_E = 1;
    repeat (CMAX + 5) tick();
    @(negedge clk);
    n_cmp++; if (flush_cnt !== CNT_W'(CMAX)) begin n_bad++; $display("FAIL flush_sat: got %0d want %0d", flush_cnt, CMAX); end
    n_cmp++; if (stall_cnt !== CNT_W'(CMAX)) begin n_bad++; $display("FAIL stall_hold: got %0d want %0d", stall_cnt, CMAX); end
    clear_inputs();
  endtask

  task automatic test_timeout_reset();
    reset_dut();
    mdu_start_E = 1;
    tick();
    repeat (TMO - 1) tick();
    @(negedge clk);
    n_cmp++; if (mdu_timeout !== 1'b0) begin n_bad++; $display("FAIL timeout_early: got %b want 0", mdu_timeout); end
    tick();
    @(negedge clk);
    n_cmp++; if (mdu_timeout !== 1'b1) begin n_bad++; $display("FAIL timeout_set: got %b want 1", mdu_timeout); end
    repeat (3) tick();
    @(negedge clk);
    n_cmp++; if (mdu_timeout !== 1'b1 || busy !== 1'b1 || ctl !== 5'b00000) begin
      n_bad++; $display("FAIL timeout_sticky: got tmo=%b busy=%b ctl=%b want 1/1/00000", mdu_timeout, busy, ctl);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (ctl !== 5'b11100 || busy !== 1'b0) begin n_bad++; $display("FAIL timeout_rst_ctl: got ctl=%b busy=%b want 11100/0", ctl, busy); end
    n_cmp++; if ({stall_cnt, flush_cnt, mdu_timeout} !== '0) begin n_bad++; $display("FAIL timeout_rst_regs: got %h/%h/%b want 0/0/0", stall_cnt, flush_cnt, mdu_timeout); end
    reset_dut();
  endtask

  task automatic test_random();
    logic       m_busy = 0, m_tmo = 0;
    int         m_wait = 0, m_stall = 0, m_flush = 0;
    logic       stall_now, lu;
    logic [4:0] e_ctl;
    logic [9:0] e_vec, got;
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      rs1_D = 5'($urandom_range(0, 3)); rs2_D = 5'($urandom_range(0, 3));
      rs1_E = 5'($urandom_range(0, 3)); rs2_E = 5'($urandom_range(0, 3));
      rd_E = 5'($urandom_range(0, 3));  rd_M = 5'($urandom_range(0, 3)); rd_W = 5'($urandom_range(0, 3));
      mem_read_E = 1'($urandom_range(0, 1));
      reg_write_M = 1'($urandom_range(0, 1)); reg_write_W = 1'($urandom_range(0, 1));
      br_taken_E = ($urandom_range(0, 5) == 0);
      mdu_start_E = m_busy ? 1'b1 : ($urandom_range(0, 4) == 0);
      mdu_done = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      @(negedge clk);
      stall_now = m_busy ? !mdu_done : mdu_start_E;
      lu = mem_read_E && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D);
      if (stall_now)       e_ctl = 5'b00000;
      else if (br_taken_E) e_ctl = 5'b11111;
      else if (lu)         e_ctl = 5'b00101;
      else                 e_ctl = 5'b11100;
      exp_q.push_back({e_ctl, ref_fwd(rs1_E, reg_write_M, rd_M, reg_write_W, rd_W),
                       ref_fwd(rs2_E, reg_write_M, rd_M, reg_write_W, rd_W), m_busy});
      e_vec = exp_q.pop_front();
      got = {ctl, fwd_a_E, fwd_b_E, busy};
      n_cmp++; if (got !== e_vec) begin n_bad++; $display("FAIL rand_ctl_%0d: got %b want %b", i, got, e_vec); end
      n_cmp++; if (stall_cnt !== CNT_W'(m_stall) || flush_cnt !== CNT_W'(m_flush)) begin
        n_bad++; $display("FAIL rand_cnt_%0d: got %0d/%0d want %0d/%0d", i, stall_cnt, flush_cnt, m_stall, m_flush);
      end
      n_cmp++; if (mdu_timeout !== m_tmo) begin n_bad++; $display("FAIL rand_tmo_%0d: got %b want %b", i, mdu_timeout, m_tmo); end
      if (!e_ctl[3] && m_stall < CMAX) m_stall++;
      if (e_ctl[1] && m_flush < CMAX)  m_flush++;
      if (m_busy) begin
        m_wait++;
        if (m_wait == TMO) m_tmo = 1;
        if (mdu_done) m_busy = 0;
      end else if (mdu_start_E) begin
        m_busy = 1;
        m_wait = 0;
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_load_use_x0();
    test_branch_priority();
    test_mdu();
    test_forwarding();
    test_saturation();
    test_timeout_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
